// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and widths for the UART receive path.
package uart_pkg;
  localparam int DEF_CLKS_PER_BIT = 87;
  localparam int BYTE_W = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_e;
endpackage

// File: rtl/uart_rx_fifo2.sv
// uart_rx_fifo2: 2-entry valid/ready byte buffer; a push into a full buffer without a pop is dropped and flagged.
module uart_rx_fifo2
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] din_i,
  input  logic              ready_i,
  output logic [BYTE_W-1:0] dout_o,
  output logic              valid_o,
  output logic              overrun_o
);
  logic [BYTE_W-1:0] mem_q [2];
  logic wr_q, rd_q, overrun_q, full, pop, wr_en;
  logic [1:0] cnt_q;
  assign full = cnt_q[1];
  assign valid_o = |cnt_q;
  assign dout_o = mem_q[rd_q];
  assign overrun_o = overrun_q;
  assign pop = valid_o & ready_i;
  // A simultaneous pop frees the head slot, so a push into a full buffer still lands.
  assign wr_en = push_i & (~full | pop);
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      cnt_q <= 2'd0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_en) mem_q[wr_q] <= din_i;
      wr_q <= wr_q ^ wr_en;
      rd_q <= rd_q ^ pop;
      cnt_q <= cnt_q + {1'b0, wr_en} - {1'b0, pop};
      overrun_q <= push_i & full & ~pop;
    end
  end
endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: UART 8N1 receiver feeding a 2-entry valid/ready buffer.
// Defining UART_BYTE_RX_PARITY_EN adds an even-parity bit and the parity_err output.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun,
`ifdef UART_BYTE_RX_PARITY_EN
  output logic              parity_err,
`endif
  output logic              busy
);
  localparam logic [11:0] RELOAD = 12'(CLKS_PER_BIT - 1);
  localparam logic [11:0] HALF = 12'(CLKS_PER_BIT / 2 - 1);
`ifdef UART_BYTE_RX_PARITY_EN
  localparam state_e AFTER_DATA = PARITY;
`else
  localparam state_e AFTER_DATA = STOP;
`endif
  state_e state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic rxs, rxs_prev_q, tick, good, push, ferr_q, ferr_d, stop_tick;
  logic [11:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
`ifdef UART_BYTE_RX_PARITY_EN
  logic par_q, par_d, perr_q, perr_d;
  assign good = ~^{shift_q, par_q};
  assign perr_d = stop_tick & rxs & ~good;
  assign parity_err = perr_q;
`else
  assign good = 1'b1;
`endif
  assign rxs = sync_q[SYNC_STAGES-1];
  assign tick = cnt_q == 12'd0;
  assign stop_tick = (state_q == STOP) & tick;
  assign push = stop_tick & rxs & good;
  assign ferr_d = stop_tick & ~rxs;
  assign busy = state_q != IDLE;
  assign frame_err = ferr_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      rxs_prev_q <= 1'b1;
      state_q <= IDLE;
      cnt_q <= 12'd0;
      idx_q <= 3'd0;
      shift_q <= '0;
      ferr_q <= 1'b0;
`ifdef UART_BYTE_RX_PARITY_EN
      par_q <= 1'b0;
      perr_q <= 1'b0;
`endif
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      rxs_prev_q <= rxs;
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      ferr_q <= ferr_d;
`ifdef UART_BYTE_RX_PARITY_EN
      par_q <= par_d;
      perr_q <= perr_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = tick ? RELOAD : cnt_q - 12'd1;
    idx_d = idx_q;
    shift_d = shift_q;
`ifdef UART_BYTE_RX_PARITY_EN
    par_d = par_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = HALF;
        if (rxs_prev_q && !rxs) state_d = START;
      end
      START: if (tick) begin
        state_d = rxs ? IDLE : DATA;
        idx_d = 3'd0;
      end
      DATA: if (tick) begin
        shift_d = {rxs, shift_q[BYTE_W-1:1]};
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = AFTER_DATA;
      end
`ifdef UART_BYTE_RX_PARITY_EN
      PARITY: if (tick) begin
        par_d = rxs;
        state_d = STOP;
      end
`endif
      STOP: if (tick) state_d = rxs ? IDLE : BREAK;
      BREAK: if (rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  uart_rx_fifo2 u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .din_i(shift_q),
    .ready_i(rx_ready),
    .dout_o(rx_data),
    .valid_o(rx_valid),
    .overrun_o(overrun)
  );
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: directed bench for uart_byte_rx at 16 clocks per bit; follows UART_BYTE_RX_PARITY_EN.
module tb_uart_byte_rx;
  localparam int CPB = 16;
`ifdef UART_BYTE_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int LAT = 11 + CPB * (NB - 1);
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun, busy;
`ifdef UART_BYTE_RX_PARITY_EN
  logic parity_err;
`endif
  always #5 clk = ~clk;
  uart_byte_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .frame_err(frame_err),
    .overrun(overrun),
`ifdef UART_BYTE_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy(busy)
  );
  int total = 0, bad = 0;
  int cyc = 0, got_n = 0, vld_n = 0, ferr_n = 0, ovr_n = 0, perr_n = 0, busy_n = 0;
  int unstable_n = 0, rise_cyc = 0;
  logic [7:0] got [256];
  logic vld_prev = 1'b0, hold_q = 1'b0;
  logic [7:0] hold_d = 8'h00;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      got[got_n[7:0]] <= rx_data;
      got_n <= got_n + 1;
    end
    if (rx_valid) vld_n <= vld_n + 1;
    if (rx_valid && !vld_prev) rise_cyc <= cyc;
    if (frame_err) ferr_n <= ferr_n + 1;
    if (overrun) ovr_n <= ovr_n + 1;
    if (busy) busy_n <= busy_n + 1;
`ifdef UART_BYTE_RX_PARITY_EN
    if (parity_err) perr_n <= perr_n + 1;
`endif
    if (rx_valid && hold_q && rx_data != hold_d) unstable_n <= unstable_n + 1;
    hold_q <= rx_valid && !rx_ready;
    hold_d <= rx_data;
    vld_prev <= rx_valid;
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask
  task automatic send(input logic [7:0] d, input logic stop, input logic flip);
    logic [10:0] f;
`ifdef UART_BYTE_RX_PARITY_EN
    f = {stop, ^d ^ flip, d, 1'b0};
`else
    f = {^d ^ flip, stop, d, 1'b0};
`endif
    for (int i = 0; i < NB; i++) begin
      rx = f[i];
      repeat (CPB) tick();
    end
  endtask
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  typedef struct {
    logic [7:0] d;
    logic stop;
    int exp_bytes;
    int exp_ferr;
  } vec_t;
  vec_t vecs [6];
  int n0, v0, f0, o0, b0, p0, c0;
  logic [7:0] fb;
  initial begin
    vecs[0] = '{8'h3C, 1'b0, 0, 1};
    vecs[1] = '{8'h55, 1'b1, 1, 0};
    vecs[2] = '{8'h00, 1'b1, 1, 0};
    vecs[3] = '{8'hFF, 1'b1, 1, 0};
    vecs[4] = '{8'h80, 1'b1, 1, 0};
    vecs[5] = '{8'h01, 1'b1, 1, 0};
    repeat (3) tick();
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    rst = 1'b0;
    idle(20);
    rx_ready = 1'b1;
    n0 = got_n; v0 = vld_n; f0 = ferr_n; c0 = cyc;
    send(8'hA5, 1'b1, 1'b0);
    idle(2 * CPB);
    chk("a5_latency", rise_cyc - c0, LAT);
    chk("a5_valid_cycles", vld_n - v0, 1);
    chk("a5_bytes", got_n - n0, 1);
    chk("a5_data", got[n0[7:0]], 8'hA5);
    chk("a5_ferr", ferr_n - f0, 0);
    chk("a5_busy_after", busy, 0);
    for (int k = 0; k < 6; k++) begin
      n0 = got_n; f0 = ferr_n;
      send(vecs[k].d, vecs[k].stop, 1'b0);
      if (!vecs[k].stop) begin
        repeat (3 * CPB) tick();
        chk("break_busy_held", busy, 1);
        rx = 1'b1;
        repeat (6) tick();
        chk("break_busy_released", busy, 0);
      end
      idle(2 * CPB);
      chk("vec_bytes", got_n - n0, vecs[k].exp_bytes);
      chk("vec_ferr", ferr_n - f0, vecs[k].exp_ferr);
      if (vecs[k].exp_bytes == 1) chk("vec_data", got[n0[7:0]], vecs[k].d);
    end
    n0 = got_n; f0 = ferr_n; b0 = busy_n;
    rx = 1'b0;
    repeat (4) tick();
    idle(30);
    chk("glitch_busy_cycles", busy_n - b0, 8);
    chk("glitch_bytes", got_n - n0, 0);
    chk("glitch_ferr", ferr_n - f0, 0);
    rx_ready = 1'b0;
    n0 = got_n; o0 = ovr_n;
    send(8'h11, 1'b1, 1'b0); idle(4);
    send(8'h22, 1'b1, 1'b0); idle(4);
    send(8'h33, 1'b1, 1'b0); idle(4);
    chk("ovr_pulses", ovr_n - o0, 1);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_head", rx_data, 8'h11);
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    chk("ovr_second", rx_data, 8'h22);
    chk("ovr_second_valid", rx_valid, 1);
    rx_ready = 1'b1; tick(); rx_ready = 1'b0;
    tick();
    chk("ovr_drained", rx_valid, 0);
    chk("ovr_read0", got[n0[7:0]], 8'h11);
    chk("ovr_read1", got[8'(n0 + 1)], 8'h22);
    send(8'hAB, 1'b1, 1'b0); idle(4);
    chk("rst_pre_valid", rx_valid, 1);
    fb = 8'hF0;
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 4; i++) begin
      rx = fb[i];
      repeat (CPB) tick();
    end
    rx = fb[4];
    repeat (8) tick();
    chk("rst_mid_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    chk("rst_mid_valid", rx_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_data", rx_data, 0);
    rst = 1'b0;
    rx_ready = 1'b1;
    idle(20);
    n0 = got_n;
    send(8'h0F, 1'b1, 1'b0);
    idle(2 * CPB);
    chk("post_rst_bytes", got_n - n0, 1);
    chk("post_rst_data", got[n0[7:0]], 8'h0F);
`ifdef UART_BYTE_RX_PARITY_EN
    n0 = got_n; p0 = perr_n; f0 = ferr_n;
    send(8'h07, 1'b1, 1'b0);
    idle(2 * CPB);
    chk("par_ok_bytes", got_n - n0, 1);
    chk("par_ok_data", got[n0[7:0]], 8'h07);
    chk("par_ok_perr", perr_n - p0, 0);
    n0 = got_n; p0 = perr_n;
    send(8'h07, 1'b1, 1'b1);
    idle(2 * CPB);
    chk("par_bad_perr", perr_n - p0, 1);
    chk("par_bad_bytes", got_n - n0, 0);
    chk("par_bad_ferr", ferr_n - f0, 0);
`endif
    chk("data_stable_while_stalled", unstable_n, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
